window_scan_scheduler: RTL and testbench
========================================

# window_scan_scheduler

Frame-level scheduler that sits directly upstream of the processor loader. It walks every candidate window origin of one image and one window size, in raster order. For each origin it drives the loader control handshake (`winSize`, `startY`, `startBlock`, `start`, `ready`, `done`) and waits for completion before issuing the next origin. When the final origin completes, it reports frame completion to the top-level sequencer.

## Interface
Parameters:
- `Y_BITS`, default `pkg_integralImageCache::integralColBits`: width of the row origin.
- `BLOCK_BITS`, default `pkg_integralImageCache::integralBlockBits`: width of the block origin.
- `WIN_BITS`, default `pkg_windowCache::windowBits`: width of the window size.
- `Y_STEP`, default 1: row stride between origins, range 1..2^Y_BITS-1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `frame_start`, in, 1: request to scan a frame. Sampled only in S_IDLE.
- `last_y`, in, Y_BITS: largest valid `startY`. Latched on accept.
- `last_block`, in, BLOCK_BITS: largest valid `startBlock`. Latched on accept.
- `win_size`, in, WIN_BITS: window size. Latched on accept.
- `pl_winSize`, out, WIN_BITS: window size driven to the loader.
- `pl_startY`, out, Y_BITS: window row origin driven to the loader.
- `pl_startBlock`, out, BLOCK_BITS: window block origin driven to the loader.
- `pl_start`, out, 1: one-cycle start pulse to the loader.
- `pl_ready`, in, 1: loader is able to accept a start.
- `pl_done`, in, 1: loader finished the current window.
- `busy`, out, 1: high from accept until `frame_done`, inclusive.
- `frame_done`, out, 1: one-cycle pulse after the last window completes.

## Operation
- States: S_Idle, S_WaitReady, S_Issue, S_WaitDone, S_Advance, S_FrameDone.
- S_Idle:
  - On `frame_start`, latch `last_y`, `last_block` and `win_size`.
  - Clear the Y and block counters to 0.
  - Go to S_WaitReady.
- S_WaitReady: stay while `pl_ready`=0. When `pl_ready`=1, go to S_Issue.
- S_Issue: `pl_start`=1 for exactly this cycle. Go to S_WaitDone.
- S_WaitDone: stay until `pl_done`=1, then go to S_Advance. `pl_done` is ignored in every other state.
- S_Advance, traversal order is Y inner, block outer:
  - If Y+Y_STEP ≤ last_y, then Y += Y_STEP.
  - Else Y = 0. Then, if block < last_block, block += 1; otherwise the frame is complete.
  - The Y sum is evaluated at Y_BITS+1 width, so it never wraps.
  - Next state is S_WaitReady, or S_FrameDone if the frame is complete.
- S_FrameDone: `frame_done`=1 for one cycle. Go to S_Idle.
- Window count per frame = (floor(last_y/Y_STEP)+1) × (last_block+1).
- `last_y`=0 or `last_block`=0 is legal and yields a single row or a single column of windows.
- `pl_winSize`, `pl_startY` and `pl_startBlock` are registered. They are stable from S_Issue through the end of S_WaitDone.
- `frame_start` while `busy`=1 is ignored. Input changes after accept are ignored.
- Reset, including mid-frame: state goes to S_Idle and all outputs go to 0 (`pl_*`, `busy`, `frame_done`). No `frame_done` is generated for an aborted frame.

## Timing
- All outputs are registered. Nothing is combinational from any input.
- `frame_start` accepted at edge N:
  - `busy`=1 from N+1.
  - With `pl_ready` already 1, `pl_start`=1 in cycle N+2.
- `pl_done` seen at edge M:
  - The next `pl_start` is at M+3 if `pl_ready`=1 (S_Advance, S_WaitReady, S_Issue).
  - `frame_done` is at M+2 for the last window.
- `busy` drops in the cycle after `frame_done`.
- `pl_start` never reasserts before the matching `pl_done`. At most one window is outstanding.

## Configuration
- Macro `WINDOW_SCAN_COUNT_EN`.
- Defined:
  - Adds output `windows_issued`, width Y_BITS+BLOCK_BITS+1.
  - Cleared on accept, incremented in each S_Issue cycle, held after `frame_done` until the next accept, reset to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- `last_y`=3, `last_block`=1, Y_STEP=1, `pl_ready` tied 1, `pl_done` 5 cycles after each start -> 8 starts with (Y,block) = (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1); then `frame_done` exactly once; `windows_issued`=8 if enabled.
- Y_STEP=2, `last_y`=5, `last_block`=0 -> origins Y=0,2,4 only; 3 starts; `frame_done` 2 cycles after the third `pl_done`.
- `pl_ready` held 0 for 10 cycles after accept -> no `pl_start` until `pl_ready` rises; `pl_start` is 1 cycle wide, 1 cycle after the rise.
- Spurious `pl_done` in S_Idle and S_WaitReady, plus a second `frame_start` mid-frame -> counters unaffected; origin sequence unchanged.
- `last_y`=2^Y_BITS-1, Y_STEP=1 -> Y reaches the maximum and then returns to 0 with block+1; no wrap-induced extra windows.
- `rst` asserted while in S_WaitDone -> immediate: `busy`=0, `pl_start`=0, no `frame_done`; a new `frame_start` restarts the scan at (0,0).

Source files
------------

// File: rtl/window_scan_scheduler.sv
// window_scan_scheduler
//
// Frame-level scheduler that sits directly upstream of the processor loader.
// It walks every window origin of one frame in raster order, with Y as the
// inner loop and block as the outer loop. For each origin it waits for the
// loader to be ready, issues a one-cycle start, and waits for the loader's
// done before it moves to the next origin. A one-cycle frame_done pulse
// follows completion of the final window.
//
// Optional feature: define WINDOW_SCAN_COUNT_EN to add the windows_issued
// output. This output counts the starts issued since the last accept.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   frame_start          scan request, sampled only while idle
//   last_y, last_block   largest valid origin, latched on accept
//   win_size             window size, latched on accept
//   pl_winSize           window size to the loader (registered)
//   pl_startY            row origin to the loader (registered)
//   pl_startBlock        block origin to the loader (registered)
//   pl_start             one-cycle start pulse to the loader
//   pl_ready, pl_done    loader handshake inputs
//   busy                 high from accept through frame_done
//   frame_done           one-cycle pulse after the last window completes
//   windows_issued       (WINDOW_SCAN_COUNT_EN only) starts issued this frame
module window_scan_scheduler #(
  parameter int unsigned Y_BITS     = 8,
  parameter int unsigned BLOCK_BITS = 6,
  parameter int unsigned WIN_BITS   = 5,
  parameter int unsigned Y_STEP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [Y_BITS-1:0]     last_y,
  input  logic [BLOCK_BITS-1:0] last_block,
  input  logic [WIN_BITS-1:0]   win_size,
  output logic [WIN_BITS-1:0]   pl_winSize,
  output logic [Y_BITS-1:0]     pl_startY,
  output logic [BLOCK_BITS-1:0] pl_startBlock,
  output logic                  pl_start,
  input  logic                  pl_ready,
  input  logic                  pl_done,
  output logic                  busy,
  output logic                  frame_done
`ifdef WINDOW_SCAN_COUNT_EN
  ,
  output logic [Y_BITS+BLOCK_BITS:0] windows_issued
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_ISSUE,
    S_WAIT_DONE,
    S_ADVANCE,
    S_FRAME_DONE
  } state_t;

  localparam logic [Y_BITS:0] Y_STEP_W = Y_STEP[Y_BITS:0];

  state_t                state;
  state_t                state_next;
  logic [Y_BITS-1:0]     last_y_q;
  logic [BLOCK_BITS-1:0] last_block_q;
  logic [Y_BITS:0]       y_sum;
  logic                  y_fits;
  logic                  block_last;
  logic                  frame_end;
  logic                  accept;
  logic                  start_next;
  logic                  busy_next;
  logic                  frame_done_next;

  // The Y sum carries one extra bit so that a large step near the top of the
  // range cannot wrap and produce a spurious extra row.
  assign y_sum      = {1'b0, pl_startY} + Y_STEP_W;
  assign y_fits     = (y_sum <= {1'b0, last_y_q});
  assign block_last = (pl_startBlock == last_block_q);
  assign frame_end  = !y_fits && block_last;
  assign accept     = (state == S_IDLE) && frame_start;

  // State register together with the registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pl_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      pl_start   <= start_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (frame_start) state_next = S_WAIT_READY;
      S_WAIT_READY: if (pl_ready)    state_next = S_ISSUE;
      S_ISSUE:                       state_next = S_WAIT_DONE;
      S_WAIT_DONE:  if (pl_done)     state_next = S_ADVANCE;
      S_ADVANCE:    state_next = frame_end ? S_FRAME_DONE : S_WAIT_READY;
      S_FRAME_DONE:                  state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // The outputs are decoded from the next state and then registered. As a
  // result, each output is asserted in the same cycle as the state it
  // belongs to, with no combinational path from any input.
  always_comb begin
    start_next      = (state_next == S_ISSUE);
    busy_next       = (state_next != S_IDLE);
    frame_done_next = (state_next == S_FRAME_DONE);
  end

  // Origin counters double as the loader origin outputs. They change only on
  // accept and in S_ADVANCE, so they stay stable from issue through done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_winSize    <= '0;
      pl_startY     <= '0;
      pl_startBlock <= '0;
      last_y_q      <= '0;
      last_block_q  <= '0;
    end else if (accept) begin
      pl_winSize    <= win_size;
      pl_startY     <= '0;
      pl_startBlock <= '0;
      last_y_q      <= last_y;
      last_block_q  <= last_block;
    end else if (state == S_ADVANCE) begin
      if (y_fits) begin
        pl_startY <= y_sum[Y_BITS-1:0];
      end else begin
        pl_startY <= '0;
        if (!block_last) pl_startBlock <= pl_startBlock + 1'b1;
      end
    end
  end

`ifdef WINDOW_SCAN_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      windows_issued <= '0;
    end else if (accept) begin
      windows_issued <= '0;
    end else if (state == S_ISSUE) begin
      windows_issued <= windows_issued + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_window_scan_scheduler.sv
// Directed testbench for window_scan_scheduler. Two instances share one clock
// and one reset: u_step1 (Y_STEP=1) and u_step2 (Y_STEP=2). A simple loader
// model raises done five cycles after each start it sees.
module tb_window_scan_scheduler;
  localparam int YB = 3;
  localparam int BB = 2;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          fs[2];
  logic [YB-1:0] ly[2];
  logic [BB-1:0] lb[2];
  logic [WB-1:0] ws[2];
  logic          rdy[2];
  logic          dn[2];
  logic          spur[2];
  logic [WB-1:0] psw[2];
  logic [YB-1:0] psy[2];
  logic [BB-1:0] psb[2];
  logic          pls[2];
  logic          bsy[2];
  logic          fd[2];
`ifdef WINDOW_SCAN_COUNT_EN
  logic [YB+BB:0] wi[2];
`endif

  window_scan_scheduler #(.Y_BITS(YB), .BLOCK_BITS(BB), .WIN_BITS(WB), .Y_STEP(1)) u_step1 (
    .clk(clk), .rst(rst), .frame_start(fs[0]), .last_y(ly[0]), .last_block(lb[0]),
    .win_size(ws[0]), .pl_winSize(psw[0]), .pl_startY(psy[0]), .pl_startBlock(psb[0]),
    .pl_start(pls[0]), .pl_ready(rdy[0]), .pl_done(dn[0]), .busy(bsy[0]), .frame_done(fd[0])
`ifdef WINDOW_SCAN_COUNT_EN
    , .windows_issued(wi[0])
`endif
  );

  window_scan_scheduler #(.Y_BITS(YB), .BLOCK_BITS(BB), .WIN_BITS(WB), .Y_STEP(2)) u_step2 (
    .clk(clk), .rst(rst), .frame_start(fs[1]), .last_y(ly[1]), .last_block(lb[1]),
    .win_size(ws[1]), .pl_winSize(psw[1]), .pl_startY(psy[1]), .pl_startBlock(psb[1]),
    .pl_start(pls[1]), .pl_ready(rdy[1]), .pl_done(dn[1]), .busy(bsy[1]), .frame_done(fd[1])
`ifdef WINDOW_SCAN_COUNT_EN
    , .windows_issued(wi[1])
`endif
  );

  // Loader model: done is high in the fifth cycle after the start cycle.
  int lcnt[2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt[0] <= 0;
      lcnt[1] <= 0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pls[s]) lcnt[s] <= 5;
        else if (lcnt[s] > 0) lcnt[s] <= lcnt[s] - 1;
      end
    end
  end
  assign dn[0] = (lcnt[0] == 1) || spur[0];
  assign dn[1] = (lcnt[1] == 1) || spur[1];

  // Monitor: record every start (origin, size, cycle) and every frame_done.
  int st_cnt[2];
  int st_y[2][64];
  int st_b[2][64];
  int st_w[2][64];
  int st_t[2][64];
  int fd_cnt[2];
  int fd_t[2];
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (pls[s]) begin
        if (st_cnt[s] < 64) begin
          st_y[s][st_cnt[s]] = int'(psy[s]);
          st_b[s][st_cnt[s]] = int'(psb[s]);
          st_w[s][st_cnt[s]] = int'(psw[s]);
          st_t[s][st_cnt[s]] = cyc;
        end
        st_cnt[s]++;
      end
      if (fd[s]) begin
        fd_cnt[s]++;
        fd_t[s] = cyc;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear(input int s);
    st_cnt[s] = 0;
    fd_cnt[s] = 0;
    fd_t[s]   = 0;
  endtask

  task automatic pulse_fs(input int s, input int y, input int b, input int w);
    ly[s] = YB'(y);
    lb[s] = BB'(b);
    ws[s] = WB'(w);
    fs[s] = 1'b1;
    tick();
    fs[s] = 1'b0;
  endtask

  // n returns the edge number at which the request is accepted.
  task automatic accept(input int s, input int y, input int b, input int w, output int n);
    n = cyc + 1;
    pulse_fs(s, y, b, w);
    chk("busy_after_accept", bsy[s], 1);
  endtask

  task automatic wait_fd(input int s, input int budget);
    int k = 0;
    while (fd_cnt[s] == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("frame_done_seen", fd_cnt[s] != 0, 1);
  endtask

  task automatic wait_starts(input int s, input int n, input int budget);
    int k = 0;
    while (st_cnt[s] < n && k < budget) begin
      tick();
      k++;
    end
    chk("start_seen", st_cnt[s] >= n, 1);
  endtask

  task automatic post_frame(input int s);
    tick();
    chk("busy_drop", bsy[s], 0);
    chk("frame_done_width", fd[s], 0);
    repeat (3) tick();
    chk("frame_done_once", fd_cnt[s], 1);
  endtask

  // Expected origins: rows 0, step, 2*step ... up to last_y, repeated per block.
  task automatic chk_origins(input int s, input int step, input int ly_v, input int lb_v,
                             input int w);
    int rows = ly_v / step + 1;
    int total = rows * (lb_v + 1);
    chk("start_count", st_cnt[s], total);
    for (int k = 0; k < total && k < 64; k++) begin
      chk("origin_y", st_y[s][k], (k % rows) * step);
      chk("origin_block", st_b[s][k], k / rows);
      chk("origin_win", st_w[s][k], w);
    end
`ifdef WINDOW_SCAN_COUNT_EN
    chk("windows_issued", wi[s], total);
`endif
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      fs[s] = 1'b0; ly[s] = '0; lb[s] = '0; ws[s] = '0; rdy[s] = 1'b0; spur[s] = 1'b0;
      clear(s);
    end
    repeat (3) tick();
    chk("rst_busy", bsy[0], 0);
    chk("rst_start", pls[0], 0);
    chk("rst_frame_done", fd[0], 0);
    chk("rst_y", psy[0], 0);
    chk("rst_block", psb[0], 0);
    chk("rst_win", psw[0], 0);
    chk("rst_busy_b", bsy[1], 0);
    rst = 1'b0;
    tick();

    // 4x2 frame with the loader always ready: eight starts spaced 8 cycles apart.
    clear(0);
    rdy[0] = 1'b1;
    accept(0, 3, 1, 9, n);
    wait_fd(0, 200);
    chk("t1_fd_time", fd_t[0], n + 64);
    post_frame(0);
    chk_origins(0, 1, 3, 1, 9);
    for (int k = 0; k < 8; k++) chk("t1_start_time", st_t[0][k], n + 1 + 8 * k);

    // Loader not ready for 10 cycles; single-window frame.
    clear(0);
    rdy[0] = 1'b0;
    accept(0, 0, 0, 4, n);
    repeat (10) tick();
    chk("no_start_unready", st_cnt[0], 0);
    r = cyc + 1;
    rdy[0] = 1'b1;
    wait_fd(0, 50);
    chk("start_after_ready", st_t[0][0], r);
    post_frame(0);
    chk_origins(0, 1, 0, 0, 4);

    // Spurious done in idle and in wait-ready, plus repeat requests mid-frame.
    clear(0);
    rdy[0] = 1'b0;
    spur[0] = 1'b1; tick(); spur[0] = 1'b0;
    chk("spur_idle_busy", bsy[0], 0);
    accept(0, 1, 1, 6, n);
    tick();
    spur[0] = 1'b1; tick(); spur[0] = 1'b0;
    pulse_fs(0, 3, 3, 2);
    rdy[0] = 1'b1;
    wait_starts(0, 1, 20);
    tick(); tick();
    pulse_fs(0, 3, 3, 2);
    wait_fd(0, 100);
    post_frame(0);
    chk_origins(0, 1, 1, 1, 6);

    // Row and block at their maximum: no wrap, 8x4 windows.
    clear(0);
    accept(0, 7, 3, 15, n);
    wait_fd(0, 400);
    post_frame(0);
    chk_origins(0, 1, 7, 3, 15);

    // Reset while the third window is outstanding, then restart.
    clear(0);
    accept(0, 3, 1, 5, n);
    wait_starts(0, 3, 100);
    tick(); tick();
    chk("pre_rst_y", psy[0], 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bsy[0], 0);
    chk("mid_rst_start", pls[0], 0);
    chk("mid_rst_y", psy[0], 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("no_fd_after_abort", fd_cnt[0], 0);
    chk("idle_after_abort", bsy[0], 0);
    clear(0);
    accept(0, 3, 1, 5, n);
    wait_fd(0, 200);
    post_frame(0);
    chk_origins(0, 1, 3, 1, 5);

    // Y_STEP=2: rows 0,2,4, then frame_done two cycles after the third done.
    clear(1);
    rdy[1] = 1'b1;
    accept(1, 5, 0, 3, n);
    wait_fd(1, 100);
    chk("s2_fd_time", fd_t[1], st_t[1][2] + 7);
    post_frame(1);
    chk_origins(1, 2, 5, 0, 3);

    // Y_STEP=2 with last_y at maximum: 6+2 must not wrap back into range.
    clear(1);
    accept(1, 7, 1, 11, n);
    wait_fd(1, 200);
    post_frame(1);
    chk_origins(1, 2, 7, 1, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
